// File: rtl/byte_unpack_pkg.sv
// ============================================================================
// Module : byte_unpack_pkg
// Brief  : Shared types and constants for the word-to-byte unpacker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package byte_unpack_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_IDLE      = 3'd0;
    localparam logic [SEL_W-1:0] SEL_FIRST_LSB = 3'd1;
    localparam logic [SEL_W-1:0] SEL_FIRST_MSB = 3'd4;

endpackage

`default_nettype wire

// File: rtl/byte_lane_mux.sv
// ============================================================================
// Module : byte_lane_mux
// Brief  : Combinational byte-lane select; sel 1..4 picks [7:0]..[31:24],
//          any other sel yields zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_mux
    import byte_unpack_pkg::*;
(
    input  logic [LANES*BYTE_W-1:0] i_word,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [BYTE_W-1:0]       o_byte
);

    always_comb begin
        o_byte = '0;
        case (i_sel)
            3'd1:    o_byte = i_word[7:0];
            3'd2:    o_byte = i_word[15:8];
            3'd3:    o_byte = i_word[23:16];
            3'd4:    o_byte = i_word[31:24];
            default: o_byte = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/byte_unpack_ctrl.sv
// ============================================================================
// Module : byte_unpack_ctrl
// Brief  : Accepts 32-bit words and hands them off one byte at a time with
//          valid/ready on both sides. Optional macro BYTE_UNPACK_EARLY_TERM_EN
//          makes a 0x00 byte terminate its word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_unpack_ctrl
    import byte_unpack_pkg::*;
#(
    parameter int N         = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  in_word,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_byte,
    output logic [N-1:0]  out_sel,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic [15:0]   byte_cnt
);

    generate
        if (N != 32) begin : g_bad_width
            $error("byte_unpack_ctrl: N must be 32");
        end
    endgenerate

    localparam logic [SEL_W-1:0] c_sel_first = (MSB_FIRST != 0) ? SEL_FIRST_MSB : SEL_FIRST_LSB;
    localparam logic [SEL_W-1:0] c_sel_last  = (MSB_FIRST != 0) ? SEL_FIRST_LSB : SEL_FIRST_MSB;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_word;
    logic [N-1:0]       w_word_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [15:0]        r_byte_cnt;
    logic [BYTE_W-1:0]  w_cur_byte;
    logic               w_last;
    logic               w_load;

    byte_lane_mux u_lane_mux (
        .i_word (r_word),
        .i_sel  (r_sel),
        .o_byte (w_cur_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_sel      <= SEL_IDLE;
            r_byte_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_sel   <= w_sel_nxt;
            if (out_valid && out_ready) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_sel_nxt   = r_sel;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_last      = 1'b0;
        in_ready    = 1'b1;
        w_load      = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
`ifdef BYTE_UNPACK_EARLY_TERM_EN
                w_last    = (r_sel == c_sel_last) || (w_cur_byte == '0);
`else
                w_last    = (r_sel == c_sel_last);
`endif
                in_ready  = w_last && out_ready;
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_sel_nxt   = SEL_IDLE;
                    end else if (MSB_FIRST != 0) begin
                        w_sel_nxt = r_sel - 3'd1;
                    end else begin
                        w_sel_nxt = r_sel + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = SEL_IDLE;
            end
        endcase

        // A load overrides the return to IDLE so back-to-back words have no bubble.
        w_load = in_valid && in_ready;
        if (w_load) begin
            w_state_nxt = EMIT;
            w_word_nxt  = in_word;
            w_sel_nxt   = c_sel_first;
        end
    end

    assign out_byte = w_cur_byte;
    assign out_last = w_last;
    assign out_sel  = {{(N-SEL_W){1'b0}}, r_sel};
    assign byte_cnt = r_byte_cnt;

endmodule

`default_nettype wire

// File: tb/tb_byte_unpack_ctrl.sv
// ============================================================================
// Module : tb_byte_unpack_ctrl
// Brief  : Self-checking bench for byte_unpack_ctrl, LSB-first and MSB-first
//          instances driven in parallel against a queue-based byte model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_unpack_ctrl;

`ifdef BYTE_UNPACK_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        logic [2:0] sel;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = '0;
    logic        out_ready = 1'b1;

    logic        ir0, ov0, ol0, bz0, ir1, ov1, ol1, bz1;
    logic [7:0]  ob0, ob1;
    logic [31:0] os0, os1;
    logic [15:0] bc0, bc1;

    int n_vec = 0;
    int n_err = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] mc0 = '0;
    logic [15:0] mc1 = '0;
    bit          acc0, acc1;

    always #5 clk = ~clk;

    byte_unpack_ctrl #(.N(32), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .in_ready(ir0), .out_valid(ov0), .out_byte(ob0), .out_sel(os0),
        .out_last(ol0), .out_ready(out_ready), .busy(bz0), .byte_cnt(bc0)
    );

    byte_unpack_ctrl #(.N(32), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .in_ready(ir1), .out_valid(ov1), .out_byte(ob1), .out_sel(os1),
        .out_last(ol1), .out_ready(out_ready), .busy(bz1), .byte_cnt(bc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word becomes a list of bytes in emit order, cut after a zero byte when early-term is on.
    task automatic push_word(input int m, input logic [31:0] w);
        exp_t e;
        int   lane;
        for (int k = 0; k < 4; k++) begin
            lane   = (m == 1) ? 3 - k : k;
            e.b    = w[8*lane +: 8];
            e.sel  = 3'(lane + 1);
            e.last = (k == 3) || (ET && (e.b == 8'h00));
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            if (e.last) break;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete(); q1.delete();
            mc0 = '0; mc1 = '0;
        end else begin
            acc0 = in_valid && (q0.size() == 0 || (q0.size() == 1 && out_ready));
            acc1 = in_valid && (q1.size() == 0 || (q1.size() == 1 && out_ready));
            if (q0.size() > 0 && out_ready) begin void'(q0.pop_front()); mc0 = mc0 + 16'd1; end
            if (q1.size() > 0 && out_ready) begin void'(q1.pop_front()); mc1 = mc1 + 16'd1; end
            if (acc0) push_word(0, in_word);
            if (acc1) push_word(1, in_word);
        end
    end

    task automatic cmp_inst(input string t, input int sz, input exp_t f,
                            input logic ov, input logic bz, input logic ir, input logic ol,
                            input logic [7:0] ob, input logic [31:0] os,
                            input logic [15:0] bc, input logic [15:0] mc);
        chk({t, ".out_valid"}, 32'(ov), 32'(sz > 0));
        chk({t, ".busy"},      32'(bz), 32'(sz > 0));
        chk({t, ".in_ready"},  32'(ir), 32'(sz == 0 || (sz == 1 && out_ready)));
        chk({t, ".byte_cnt"},  32'(bc), 32'(mc));
        if (sz > 0) begin
            chk({t, ".out_byte"}, 32'(ob), 32'(f.b));
            chk({t, ".out_sel"},  os,      32'(f.sel));
            chk({t, ".out_last"}, 32'(ol), 32'(f.last));
        end else begin
            chk({t, ".out_sel_idle"}, os, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        exp_t f0, f1;
        f0 = '{b: 8'h00, sel: 3'd0, last: 1'b0};
        f1 = f0;
        if (q0.size() > 0) f0 = q0[0];
        if (q1.size() > 0) f1 = q1[0];
        cmp_inst("lsb", q0.size(), f0, ov0, bz0, ir0, ol0, ob0, os0, bc0, mc0);
        cmp_inst("msb", q1.size(), f1, ov1, bz1, ir1, ol1, ob1, os1, bc1, mc1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offers n words back to back; word k = (base + step*k) | orm.
    task automatic stream(input int n, input logic [31:0] base, input logic [31:0] step,
                          input logic [31:0] orm);
        in_word  = base | orm;
        in_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            if (k < n - 1) begin
                in_word = (base + step * 32'(k + 1)) | orm;
                repeat (3) tick();
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (4) tick();
    endtask

    task automatic offer_one(input logic [31:0] w);
        in_word  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [15:0] start_cnt;

    initial begin
        repeat (3) tick();
        chk("reset.in_ready",  32'(ir0), 32'd1);
        chk("reset.out_valid", 32'(ov0), 32'd0);
        chk("reset.out_byte",  32'(ob0), 32'd0);
        chk("reset.byte_cnt",  32'(bc0), 32'd0);
        rst = 1'b0;

        // first byte visible one cycle after acceptance
        offer_one(32'hA1B2C3D4);
        chk("lsb.first_byte", 32'(ob0), 32'hD4);
        chk("lsb.first_sel",  os0,      32'd1);
        chk("msb.first_byte", 32'(ob1), 32'hA1);
        chk("msb.first_sel",  os1,      32'd4);
        repeat (3) tick();
        chk("lsb.last_byte",  32'(ob0), 32'hA1);
        chk("lsb.last_flag",  32'(ol0), 32'd1);
        tick();
        chk("lsb.cnt_after_word", 32'(bc0), 32'd4);

        stream(2, 32'h11223344, 32'h44444444, 32'h0);
        chk("b2b.cnt", 32'(bc0), 32'd12);

        // stall on the second byte
        offer_one(32'hA1B2C3D4);
        tick();
        start_cnt = bc0;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall.byte", 32'(ob0), 32'hC3);
            chk("stall.sel",  os0,      32'd2);
            chk("stall.cnt",  32'(bc0), 32'(start_cnt));
        end
        out_ready = 1'b1;
        repeat (4) tick();

        // asynchronous reset mid-word
        offer_one(32'hDEADBEEF);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("rst.out_valid", 32'(ov0), 32'd0);
        chk("rst.byte_cnt",  32'(bc0), 32'd0);
        chk("rst.msb_valid", 32'(ov1), 32'd0);
        tick();
        rst = 1'b0;
        offer_one(32'h0F1E2D3C);
        chk("rst.restart_sel",  os0,      32'd1);
        chk("rst.restart_byte", 32'(ob0), 32'h3C);
        repeat (4) tick();

        // zero byte in the middle of a word
        offer_one(32'h41004342);
        chk("zero.b0", 32'(ob0), 32'h42);
        repeat (2) tick();
        chk("zero.b2", 32'(ob0), 32'h00);
        chk("zero.b2_last", 32'(ol0), 32'(ET));
        tick();
        if (ET) chk("zero.term_idle", 32'(ov0), 32'd0);
        else    chk("zero.b3", 32'(ob0), 32'h41);
        repeat (2) tick();

        // 65536 bytes must bring the counter back around to its start value
        start_cnt = bc0;
        stream(16384, 32'h0, 32'h1, 32'h80808080);
        chk("wrap.cnt", 32'(bc0), 32'(start_cnt));
        chk("wrap.msb_cnt", 32'(bc1), 32'(start_cnt));

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
